// File: rtl/cod_display_5bits.sv
// Decodes a multiplexed active-low 7-segment bus (units/tens) back to a 0..31 value with a valid/ready handoff.
// Optional COD_DISPLAY_FILTER_EN: a digit is accepted only after two identical consecutive strobes.
module cod_display_5bits #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:6] seg_in,
  input  logic       seg_strobe,
  input  logic       seg_dig,
  output logic [4:0] S_out,
  output logic       valido,
  input  logic       pronto,
  output logic       erro,
  output logic       ocupado
);

  typedef enum logic [1:0] {IDLE, GOT_UNI, CHECK, HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       uni_dig, dez_dig;
  logic             uni_bad, dez_bad;
  logic [3:0]       dec_val;
  logic             dec_bad;
  logic [6:0]       val7;
  logic             uni_acc, dez_acc;
  logic             load_uni, load_dez, clr_cnt, inc_cnt;
  logic             set_valido, clr_valido, set_erro;

  // Segment pattern (a..g, active-low) to decimal digit
  always_comb begin
    dec_val = 4'd0;
    dec_bad = 1'b0;
    case (seg_in)
      7'b0000001: dec_val = 4'd0;
      7'b1001111: dec_val = 4'd1;
      7'b0010010: dec_val = 4'd2;
      7'b0000110: dec_val = 4'd3;
      7'b1001100: dec_val = 4'd4;
      7'b0100100: dec_val = 4'd5;
      7'b0100000: dec_val = 4'd6;
      7'b0001111: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0000100: dec_val = 4'd9;
      default:    dec_bad = 1'b1;
    endcase
  end

`ifdef COD_DISPLAY_FILTER_EN
  logic [0:6] cand_pat;
  logic       cand_dig;
  logic       cand_vld;
  logic       cand_hit;
  logic       cand_upd;

  assign cand_hit = seg_strobe && cand_vld && (cand_dig == seg_dig) && (cand_pat == seg_in);
  assign uni_acc  = cand_hit && !seg_dig;
  assign dez_acc  = cand_hit && seg_dig;
  assign cand_upd = seg_strobe && ((state == GOT_UNI) || ((state == IDLE) && !seg_dig));

  // Candidate is dropped on any state change so every frame starts fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_pat <= '0;
      cand_dig <= 1'b0;
      cand_vld <= 1'b0;
    end else if (state_nxt != state) begin
      cand_vld <= 1'b0;
    end else if (cand_upd) begin
      if (cand_hit) begin
        cand_vld <= 1'b0;
      end else begin
        cand_pat <= seg_in;
        cand_dig <= seg_dig;
        cand_vld <= 1'b1;
      end
    end
  end
`else
  assign uni_acc = seg_strobe && !seg_dig;
  assign dez_acc = seg_strobe && seg_dig;
`endif

  assign val7    = (7'(dez_dig) * 7'd10) + 7'(uni_dig);
  assign ocupado = (state == GOT_UNI) || (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_uni   = 1'b0;
    load_dez   = 1'b0;
    clr_cnt    = 1'b0;
    inc_cnt    = 1'b0;
    set_valido = 1'b0;
    clr_valido = 1'b0;
    set_erro   = 1'b0;
    case (state)
      IDLE: begin
        if (uni_acc) begin
          load_uni  = 1'b1;
          clr_cnt   = 1'b1;
          state_nxt = GOT_UNI;
        end
      end
      GOT_UNI: begin
        // A tens capture on the final allowed cycle wins over the timeout
        if (dez_acc) begin
          load_dez  = 1'b1;
          clr_cnt   = 1'b1;
          state_nxt = CHECK;
        end else if (uni_acc) begin
          load_uni = 1'b1;
          clr_cnt  = 1'b1;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          set_erro  = 1'b1;
          clr_cnt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          inc_cnt = 1'b1;
        end
      end
      CHECK: begin
        if (uni_bad || dez_bad || (val7 > 7'd31)) begin
          set_erro  = 1'b1;
          state_nxt = IDLE;
        end else begin
          set_valido = 1'b1;
          state_nxt  = HOLD;
        end
      end
      HOLD: begin
        if (pronto) begin
          clr_valido = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      uni_dig <= 4'd0;
      uni_bad <= 1'b0;
      dez_dig <= 4'd0;
      dez_bad <= 1'b0;
      S_out   <= 5'd0;
      valido  <= 1'b0;
      erro    <= 1'b0;
    end else begin
      erro <= set_erro;
      if (clr_cnt)      cnt <= '0;
      else if (inc_cnt) cnt <= cnt + CNT_W'(1);
      if (load_uni) begin
        uni_dig <= dec_val;
        uni_bad <= dec_bad;
      end
      if (load_dez) begin
        dez_dig <= dec_val;
        dez_bad <= dec_bad;
      end
      if (set_valido) begin
        S_out  <= val7[4:0];
        valido <= 1'b1;
      end else if (clr_valido) begin
        valido <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cod_display_5bits.sv
// Directed, table-driven bench for cod_display_5bits; inputs change and outputs are sampled on the falling edge.
module tb_cod_display_5bits;

  localparam int TIMEOUT = 255;
`ifdef COD_DISPLAY_FILTER_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:6] seg_in;
  logic       seg_strobe;
  logic       seg_dig;
  logic [4:0] S_out;
  logic       valido;
  logic       pronto;
  logic       erro;
  logic       ocupado;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] uni;
    logic [6:0] dez;
    logic       ok;
    logic [4:0] s_exp;
  } vec_t;

  vec_t vecs [12];

  cod_display_5bits #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_in(seg_in),
    .seg_strobe(seg_strobe),
    .seg_dig(seg_dig),
    .S_out(S_out),
    .valido(valido),
    .pronto(pronto),
    .erro(erro),
    .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Caller sits on a falling edge; the strobe is sampled by the next rising edge
  task automatic strobeOnce(input logic [6:0] pat, input logic dig);
    seg_in     = pat;
    seg_dig    = dig;
    seg_strobe = 1'b1;
    @(negedge clk);
    seg_strobe = 1'b0;
  endtask

  task automatic applyStimulus(input logic [6:0] pat, input logic dig);
    for (int r = 0; r <= EXTRA; r++) strobeOnce(pat, dig);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{7'b0000110, 7'b1001111, 1'b1, 5'd13};
    vecs[1]  = '{7'b1001111, 7'b0000110, 1'b1, 5'd31};
    vecs[2]  = '{7'b0010010, 7'b0000110, 1'b0, 5'd31};
    vecs[3]  = '{7'b1111111, 7'b0000001, 1'b0, 5'd31};
    vecs[4]  = '{7'b0000100, 7'b0000001, 1'b1, 5'd9};
    vecs[5]  = '{7'b0000001, 7'b0000001, 1'b1, 5'd0};
    vecs[6]  = '{7'b0000000, 7'b0010010, 1'b1, 5'd28};
    vecs[7]  = '{7'b0100100, 7'b0000110, 1'b0, 5'd28};
    vecs[8]  = '{7'b0000001, 7'b1111110, 1'b0, 5'd28};
    vecs[9]  = '{7'b0001111, 7'b0010010, 1'b1, 5'd27};
    vecs[10] = '{7'b0100000, 7'b1001111, 1'b1, 5'd16};
    vecs[11] = '{7'b1001100, 7'b0000001, 1'b1, 5'd4};

    rst_n = 1'b0; seg_in = 7'b1111111; seg_strobe = 1'b0; seg_dig = 1'b0; pronto = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset S_out", int'(S_out), 0);
    checkOutput("reset valido", int'(valido), 0);
    checkOutput("reset erro", int'(erro), 0);
    checkOutput("reset ocupado", int'(ocupado), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full frames from the table
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].uni, 1'b0);
      checkOutput($sformatf("v%0d ocupado after units", i), int'(ocupado), 1);
      applyStimulus(vecs[i].dez, 1'b1);
      checkOutput($sformatf("v%0d valido N+1", i), int'(valido), 0);
      checkOutput($sformatf("v%0d erro N+1", i), int'(erro), 0);
      @(negedge clk);
      checkOutput($sformatf("v%0d valido N+2", i), int'(valido), int'(vecs[i].ok));
      checkOutput($sformatf("v%0d erro N+2", i), int'(erro), int'(!vecs[i].ok));
      checkOutput($sformatf("v%0d S_out", i), int'(S_out), int'(vecs[i].s_exp));
      checkOutput($sformatf("v%0d ocupado N+2", i), int'(ocupado), int'(vecs[i].ok));
      if (vecs[i].ok) begin
        pronto = 1'b1;
        @(negedge clk);
        pronto = 1'b0;
        checkOutput($sformatf("v%0d valido after pronto", i), int'(valido), 0);
      end else begin
        @(negedge clk);
        checkOutput($sformatf("v%0d erro one cycle", i), int'(erro), 0);
      end
      checkOutput($sformatf("v%0d back to idle", i), int'(ocupado), 0);
    end

    // Tens capture on the last allowed cycle before timeout
    applyStimulus(7'b0000001, 1'b0);
    repeat (TIMEOUT - 1 - EXTRA) @(negedge clk);
    applyStimulus(7'b1001111, 1'b1);
    checkOutput("late tens no erro", int'(erro), 0);
    @(negedge clk);
    checkOutput("late tens valido", int'(valido), 1);
    checkOutput("late tens S_out", int'(S_out), 10);
    pronto = 1'b1;
    @(negedge clk);
    pronto = 1'b0;

    // Timeout with no tens strobe
    begin
      int early = 0;
      applyStimulus(7'b0000001, 1'b0);
      for (int k = 1; k < TIMEOUT; k++) begin
        @(negedge clk);
        if (erro || !ocupado) early++;
      end
      checkOutput("timeout premature", early, 0);
    end
    @(negedge clk);
    checkOutput("timeout erro", int'(erro), 1);
    checkOutput("timeout ocupado", int'(ocupado), 0);
    applyStimulus(7'b1001111, 1'b1);
    checkOutput("tens after timeout ocupado", int'(ocupado), 0);
    @(negedge clk);
    checkOutput("tens after timeout valido", int'(valido), 0);
    checkOutput("tens after timeout erro", int'(erro), 0);

    // Hold with pronto low while strobes keep arriving
    applyStimulus(7'b0000001, 1'b0);
    applyStimulus(7'b0010010, 1'b1);
    @(negedge clk);
    checkOutput("hold valido", int'(valido), 1);
    checkOutput("hold S_out", int'(S_out), 20);
    begin
      int held_bad = 0;
      for (int k = 0; k < 10; k++) begin
        strobeOnce((k % 2 == 0) ? 7'b0000110 : 7'b1001111, 1'(k % 2));
        if (!valido || S_out != 5'd20 || erro) held_bad++;
      end
      checkOutput("hold stable under strobes", held_bad, 0);
    end
    pronto = 1'b1;
    @(negedge clk);
    pronto = 1'b0;
    checkOutput("hold release valido", int'(valido), 0);
    checkOutput("hold release S_out", int'(S_out), 20);
    repeat (3) @(negedge clk);
    checkOutput("no queued frame", int'(valido | erro | ocupado), 0);

    // Reset mid-frame
    applyStimulus(7'b0000110, 1'b0);
    checkOutput("pre-reset ocupado", int'(ocupado), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset ocupado", int'(ocupado), 0);
    checkOutput("async reset S_out", int'(S_out), 0);
    checkOutput("async reset valido", int'(valido), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(7'b1001111, 1'b1);
    checkOutput("tens after reset ocupado", int'(ocupado), 0);
    @(negedge clk);
    checkOutput("tens after reset valido", int'(valido), 0);
    checkOutput("tens after reset erro", int'(erro), 0);

`ifdef COD_DISPLAY_FILTER_EN
    strobeOnce(7'b0000110, 1'b0);
    strobeOnce(7'b0000001, 1'b0);
    checkOutput("filter mismatch waits", int'(ocupado), 0);
    strobeOnce(7'b0000001, 1'b0);
    checkOutput("filter match accepts", int'(ocupado), 1);
    strobeOnce(7'b1001111, 1'b1);
    strobeOnce(7'b1001111, 1'b1);
    @(negedge clk);
    checkOutput("filter valido", int'(valido), 1);
    checkOutput("filter units zero", int'(S_out), 10);
    pronto = 1'b1;
    @(negedge clk);
    pronto = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
